// File: rtl/sh_mem_port_pkg.sv
// rtl/sh_mem_port_pkg.sv - shared sizes, request encodings and FSM states for sh_mem_port
package sh_mem_port_pkg;

  localparam int REG_SIZE  = 16;
  localparam int ADDR_SIZE = 10;

  localparam logic [1:0] MEM_REQ_NONE = 2'b00;
  localparam logic [1:0] MEM_REQ_RD   = 2'b01;
  localparam logic [1:0] MEM_REQ_WR   = 2'b10;

  localparam logic [1:0] SMP_IDLE  = 2'd0;
  localparam logic [1:0] SMP_ISSUE = 2'd1;
  localparam logic [1:0] SMP_WAIT  = 2'd2;
  localparam logic [1:0] SMP_GAP   = 2'd3;

  function automatic logic [1:0] mem_req_enc(input logic we);
    return we ? MEM_REQ_WR : MEM_REQ_RD;
  endfunction

endpackage

// File: rtl/sh_req_fifo.sv
// rtl/sh_req_fifo.sv - small synchronous request FIFO; push while full is taken only alongside a pop
module sh_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sh_mem_port.sv
// rtl/sh_mem_port.sv - core-side shared-memory initiator: request queue, issue/wait/gap FSM, completion pulses
module sh_mem_port
  import sh_mem_port_pkg::*;
#(
  parameter int DATA_W = REG_SIZE,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              st_done,
  output logic [1:0]        mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [7:0]        wait_cycles
);

  localparam int EW = 1 + ADDR_W + DATA_W;

  logic [1:0]        state_q, state_d;
  logic [1:0]        en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              st_done_q, st_done_d;
  logic [7:0]        wait_q, wait_d;

  logic          push, pop, full, empty;
  logic [EW-1:0] push_data, head, nxt;

  assign push      = req_valid && !full;
  assign push_data = {req_we, req_addr, req_wdata};

  sh_req_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // In GAP a request pushed this same cycle into an empty queue is issued next.
  assign nxt = empty ? push_data : head;

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    st_done_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    wait_d      = wait_q;
    pop         = 1'b0;
    case (state_q)
      SMP_IDLE: begin
        if (!empty) begin
          state_d = SMP_ISSUE;
          en_d    = mem_req_enc(head[EW-1]);
          addr_d  = head[DATA_W +: ADDR_W];
          wdata_d = head[DATA_W-1:0];
        end
      end
      SMP_ISSUE: state_d = SMP_WAIT;
      SMP_WAIT: begin
        if (mem_ready) begin
          pop     = 1'b1;
          state_d = SMP_GAP;
          en_d    = MEM_REQ_NONE;
          addr_d  = '0;
          wdata_d = '0;
          if (head[EW-1]) begin
            st_done_d = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_rdata;
          end
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      SMP_GAP: begin
        if (!empty || push) begin
          state_d = SMP_ISSUE;
          en_d    = mem_req_enc(nxt[EW-1]);
          addr_d  = nxt[DATA_W +: ADDR_W];
          wdata_d = nxt[DATA_W-1:0];
        end else begin
          state_d = SMP_IDLE;
        end
      end
      default: begin
        state_d = SMP_IDLE;
        en_d    = MEM_REQ_NONE;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SMP_IDLE;
      en_q        <= MEM_REQ_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      st_done_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      st_done_q   <= st_done_d;
      wait_q      <= wait_d;
    end
  end

  assign req_ready   = !full;
  assign mem_enable  = en_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign st_done     = st_done_q;
  assign wait_cycles = wait_q;
  assign busy        = !empty || (state_q != SMP_IDLE);

endmodule

// File: tb/tb_sh_mem_port.sv
// tb/tb_sh_mem_port.sv - directed bench for sh_mem_port with a response scoreboard
module tb_sh_mem_port;
  import sh_mem_port_pkg::*;

  localparam int DW = REG_SIZE;
  localparam int AW = ADDR_SIZE;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, st_done;
  logic [DW-1:0] rsp_data;
  logic [1:0]    mem_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [7:0]    wait_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          st;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic          auto_rd;
  logic [DW-1:0] rdata_drv;

  logic [1:0] b2b_en [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
  logic       b2b_rr [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(16'h5A00);
  endfunction

  assign mem_rdata = auto_rd ? rd_model(mem_addr) : rdata_drv;

  sh_mem_port dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .st_done     (st_done),
    .mem_enable  (mem_enable),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .wait_cycles (wait_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_rd);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20 && !req_ready; i++) tick;
    if (!req_ready) chk("push_timeout", 32'(req_ready), 32'd1);
    e.st   = we;
    e.data = we ? '0 : exp_rd;
    exp_q.push_back(e);
    tick;
    req_valid = 1'b0;
  endtask

  // Response monitor: every completion pulse must match the oldest expectation.
  always begin
    @(posedge clk);
    #2;
    if (rsp_valid === 1'b1 || st_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {30'b0, st_done, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_kind", {30'b0, st_done, rsp_valid}, mon_e.st ? 32'd2 : 32'd1);
        if (!mon_e.st) chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; auto_rd = 1'b0; rdata_drv = '0;
    tick;
    tick;
    chk("rst_en", 32'(mem_enable), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_st_done", 32'(st_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wait", 32'(wait_cycles), 32'd0);
    reset = 1'b0;
    tick;

    // Single load
    push(1'b0, 10'h0A5, '0, 16'h003C);
    chk("ld_idle_en", 32'(mem_enable), 32'd0);
    chk("ld_busy", 32'(busy), 32'd1);
    tick;
    chk("ld_issue_en", 32'(mem_enable), 32'(MEM_REQ_RD));
    chk("ld_issue_addr", 32'(mem_addr), 32'h0A5);
    tick;
    mem_ready = 1'b1; rdata_drv = 16'h003C;
    chk("ld_wait_en", 32'(mem_enable), 32'(MEM_REQ_RD));
    tick;
    mem_ready = 1'b0;
    chk("ld_gap_en", 32'(mem_enable), 32'd0);
    chk("ld_gap_addr", 32'(mem_addr), 32'd0);
    tick;
    chk("ld_pulse_once", 32'(rsp_valid), 32'd0);
    chk("ld_wait_cnt", 32'(wait_cycles), 32'd0);
    chk("ld_rsp_hold", 32'(rsp_data), 32'h3C);

    // Spurious ready in ISSUE and GAP
    push(1'b0, 10'h033, '0, 16'h0022);
    push(1'b0, 10'h044, '0, 16'h0055);
    chk("sp_issue_en", 32'(mem_enable), 32'(MEM_REQ_RD));
    chk("sp_issue_addr", 32'(mem_addr), 32'h033);
    mem_ready = 1'b1; rdata_drv = 16'h0011;
    tick;
    chk("sp_issue_no_rsp", 32'(rsp_valid), 32'd0);
    chk("sp_wait_en", 32'(mem_enable), 32'(MEM_REQ_RD));
    rdata_drv = 16'h0022;
    tick;
    chk("sp_gap_en", 32'(mem_enable), 32'd0);
    rdata_drv = 16'h0033;
    tick;
    chk("sp_gap_no_rsp", 32'(rsp_valid), 32'd0);
    chk("sp_issue2_en", 32'(mem_enable), 32'(MEM_REQ_RD));
    chk("sp_issue2_addr", 32'(mem_addr), 32'h044);
    rdata_drv = 16'h0044;
    tick;
    chk("sp_issue2_no_rsp", 32'(rsp_valid), 32'd0);
    rdata_drv = 16'h0055;
    tick;
    mem_ready = 1'b0;
    tick;
    chk("sp_idle_busy", 32'(busy), 32'd0);
    chk("sp_idle_en", 32'(mem_enable), 32'd0);

    // Contended store
    push(1'b1, 10'h112, 16'h007E, '0);
    tick;
    chk("st_issue_en", 32'(mem_enable), 32'(MEM_REQ_WR));
    chk("st_issue_addr", 32'(mem_addr), 32'h112);
    chk("st_issue_wdata", 32'(mem_wdata), 32'h7E);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("st_wait_en", 32'(mem_enable), 32'(MEM_REQ_WR));
      if (i == 4) mem_ready = 1'b1;
    end
    tick;
    mem_ready = 1'b0;
    chk("st_wait_cnt", 32'(wait_cycles), 32'd4);
    chk("st_gap_en", 32'(mem_enable), 32'd0);
    chk("st_gap_wdata", 32'(mem_wdata), 32'd0);
    chk("st_rsp_data_kept", 32'(rsp_data), 32'h55);
    tick;

    // Back-to-back queue of three
    auto_rd = 1'b1; mem_ready = 1'b1;
    push(1'b0, 10'h101, '0, rd_model(10'h101));
    push(1'b1, 10'h202, 16'h00BB, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h303; req_wdata = '0;
    mon_e.st = 1'b0; mon_e.data = rd_model(10'h303);
    exp_q.push_back(mon_e);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_en_%0d", i), 32'(mem_enable), 32'(b2b_en[i]));
      chk($sformatf("b2b_rr_%0d", i), 32'(req_ready), 32'(b2b_rr[i]));
      if (i == 3) req_valid = 1'b0;
      tick;
    end
    mem_ready = 1'b0; auto_rd = 1'b0;
    chk("b2b_done_busy", 32'(busy), 32'd0);

    // Reset while waiting with a second request queued
    push(1'b0, 10'h0AA, '0, '0);
    push(1'b0, 10'h0BB, '0, '0);
    tick;
    tick;
    chk("rst_pre_en", 32'(mem_enable), 32'(MEM_REQ_RD));
    reset = 1'b1;
    exp_q.delete();
    tick;
    reset = 1'b0; mem_ready = 1'b1; rdata_drv = 16'h0099;
    chk("rst_mid_en", 32'(mem_enable), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rr", 32'(req_ready), 32'd1);
    chk("rst_mid_wait", 32'(wait_cycles), 32'd0);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("rst_after_en", 32'(mem_enable), 32'd0);
      chk("rst_after_busy", 32'(busy), 32'd0);
    end
    mem_ready = 1'b0;

    // Wait counter saturation
    push(1'b1, 10'h3FF, 16'hBEEF, '0);
    tick;
    for (int i = 0; i < 302; i++) tick;
    chk("sat_wait", 32'(wait_cycles), 32'd255);
    chk("sat_en", 32'(mem_enable), 32'(MEM_REQ_WR));
    chk("sat_wdata", 32'(mem_wdata), 32'hBEEF);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("sat_hold", 32'(wait_cycles), 32'd255);
    tick;
    tick;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
